// File: rtl/vid_pkg.sv
// rtl/vid_pkg.sv - shared pixel, pattern and FSM types for the video timing source
package vid_pkg;

    typedef logic [23:0] rgb_t;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vtg_state_t;

    localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
    localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
    localparam rgb_t BAR_CYAN    = 24'h00FFFF;
    localparam rgb_t BAR_GREEN   = 24'h00FF00;
    localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
    localparam rgb_t BAR_RED     = 24'hFF0000;
    localparam rgb_t BAR_BLUE    = 24'h0000FF;
    localparam rgb_t BAR_BLACK   = 24'h000000;

    function automatic rgb_t bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vtg_counter.sv
// rtl/vtg_counter.sv - raster h/v counters, run/idle FSM and unregistered timing flags
module vtg_counter
    import vid_pkg::*;
#(
    parameter int H_ACTIVE  = 1280,
    parameter int H_FP      = 110,
    parameter int H_SYNC    = 40,
    parameter int H_BP      = 220,
    parameter int V_ACTIVE  = 720,
    parameter int V_FP      = 5,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 20,
    parameter int CHK_SHIFT = 5
) (
    input  logic       pixel_clk,
    input  logic       resetn,
    input  logic       en,
    output logic       running,
    output logic       load,
    output logic       line_end,
    output logic       active,
    output logic       hsync_act,
    output logic       vsync_act,
    output logic       first,
    output logic       chk_odd,
    output logic [7:0] h_lsb
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    vtg_state_t    state;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          frame_end;

    assign running   = (state == ST_RUN);
    assign line_end  = (h_cnt == HW'(H_TOTAL - 1));
    assign frame_end = line_end && (v_cnt == VW'(V_TOTAL - 1));
    // New frame parameters are captured on the edge that starts a frame
    assign load      = en && ((state == ST_IDLE) || frame_end);
    assign active    = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign hsync_act = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync_act = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    assign first     = (h_cnt == '0) && (v_cnt == '0);
    assign chk_odd   = 1'(h_cnt >> CHK_SHIFT) ^ 1'(v_cnt >> CHK_SHIFT);
    assign h_lsb     = 8'(h_cnt);

    always_ff @(posedge pixel_clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (en) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (line_end) begin
                        h_cnt <= '0;
                        if (frame_end) begin
                            v_cnt <= '0;
                            if (!en) state <= ST_IDLE;
                        end else begin
                            v_cnt <= v_cnt + VW'(1);
                        end
                    end else begin
                        h_cnt <= h_cnt + HW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vtg_pattern_source.sv
// rtl/vtg_pattern_source.sv - video timing generator with selectable RGB test patterns
module vtg_pattern_source
    import vid_pkg::*;
#(
    parameter int H_ACTIVE  = 1280,
    parameter int H_FP      = 110,
    parameter int H_SYNC    = 40,
    parameter int H_BP      = 220,
    parameter int V_ACTIVE  = 720,
    parameter int V_FP      = 5,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 20,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter int CHK_SHIFT = 5
) (
    input  logic        pixel_clk,
    input  logic        resetn,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_color,
    output logic [23:0] pixel_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        vde_out,
    output logic        frame_start,
    output logic        busy
);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = $clog2(BAR_W + 1);

    logic          running, load, line_end, active;
    logic          hsync_act, vsync_act, first, chk_odd;
    logic [7:0]    h_lsb;
    pattern_t      pat_q;
    rgb_t          solid_q;
    rgb_t          pat_pix;
    logic [BW-1:0] bar_cnt;
    logic [2:0]    bar_idx;

    vtg_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CHK_SHIFT(CHK_SHIFT)
    ) u_counter (
        .pixel_clk(pixel_clk),
        .resetn   (resetn),
        .en       (en),
        .running  (running),
        .load     (load),
        .line_end (line_end),
        .active   (active),
        .hsync_act(hsync_act),
        .vsync_act(vsync_act),
        .first    (first),
        .chk_odd  (chk_odd),
        .h_lsb    (h_lsb)
    );

    // Bar position tracks h_cnt; the last bar saturates so it absorbs any remainder
    always_ff @(posedge pixel_clk or negedge resetn) begin
        if (!resetn) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (!running || line_end) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (bar_cnt == BW'(BAR_W - 1)) begin
            bar_cnt <= '0;
            if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
        end else begin
            bar_cnt <= bar_cnt + BW'(1);
        end
    end

    always_ff @(posedge pixel_clk or negedge resetn) begin
        if (!resetn) begin
            pat_q   <= PAT_BARS;
            solid_q <= '0;
        end else if (load) begin
            pat_q   <= pattern_t'(pattern_sel);
            solid_q <= solid_color;
        end
    end

    always_comb begin
        pat_pix = '0;
        case (pat_q)
            PAT_BARS:  pat_pix = bar_color(bar_idx);
            PAT_RAMP:  pat_pix = {h_lsb, h_lsb, h_lsb};
            PAT_CHECK: pat_pix = chk_odd ? BAR_BLACK : BAR_WHITE;
            PAT_SOLID: pat_pix = solid_q;
            default:   pat_pix = '0;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge resetn) begin
        if (!resetn) begin
            pixel_out   <= '0;
            hsync_out   <= ~HSYNC_POL;
            vsync_out   <= ~VSYNC_POL;
            vde_out     <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pixel_out   <= (running && active) ? pat_pix : '0;
            hsync_out   <= (running && hsync_act) ? HSYNC_POL : ~HSYNC_POL;
            vsync_out   <= (running && vsync_act) ? VSYNC_POL : ~VSYNC_POL;
            vde_out     <= running && active;
            frame_start <= running && first;
            busy        <= running;
        end
    end

endmodule
